// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode/state encodings, flag bundle and instruction field positions for multicycle_datapath
package cpu_pkg;
    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,  OP_SUB = 5'd1,  OP_CMP = 5'd5,  OP_AND = 5'd6,  OP_OR  = 5'd7,
        OP_NOT  = 5'd8,  OP_MOV = 5'd9,  OP_LSL = 5'd10, OP_LSR = 5'd11, OP_ASR = 5'd12,
        OP_NOP  = 5'd13, OP_LD  = 5'd14, OP_ST  = 5'd15, OP_BEQ = 5'd16, OP_BGT = 5'd17,
        OP_B    = 5'd18, OP_CALL = 5'd19, OP_RET = 5'd20
    } opcode_e;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;

    typedef struct packed {
        logic e;
        logic gt;
    } flags_t;

    localparam int OP_LO  = 27;
    localparam int I_BIT  = 26;
    localparam int RD_LO  = 22;
    localparam int RS1_LO = 18;
    localparam int RS2_LO = 14;

    function automatic logic isLegal(input logic [4:0] op);
        return op <= 5'd20 && !(op inside {[5'd2:5'd4]});
    endfunction
endpackage

// File: rtl/dp_alu.sv
// dp_alu: combinational ALU with wrap-around arithmetic, shifts and compare flags
module dp_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  opcode_e           op,
    output logic [DATA_W-1:0] result,
    output logic              E,
    output logic              GT
);
    localparam int SH_W = $clog2(DATA_W);

    logic [SH_W-1:0]   sh;
    logic [DATA_W-1:0] asrRes;

    assign sh = B[SH_W-1:0];
    // kept apart from the ternary so the signed shift is not coerced to unsigned
    assign asrRes = $signed(A) >>> sh;
    assign E = A == B;
    assign GT = $signed(A) > $signed(B);

    always_comb
        result = op == OP_SUB || op == OP_CMP ? A - B :
                 op == OP_AND ? A & B :
                 op == OP_OR  ? A | B :
                 op == OP_NOT ? ~B :
                 op == OP_MOV ? B :
                 op == OP_LSL ? A << sh :
                 op == OP_LSR ? A >> sh :
                 op == OP_ASR ? asrRes :
                 A + B;
endmodule

// File: rtl/multicycle_datapath.sv
// multicycle_datapath: FETCH/DECODE/EXEC/MEM/WB sequencer with internal register file and handshaked memories
module multicycle_datapath
    import cpu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int NREG    = 16,
    parameter int IADDR_W = 10,
    parameter int DADDR_W = 10
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [IADDR_W-1:0] imem_addr,
    input  logic               imem_ack,
    input  logic [31:0]        imem_rdata,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic               dmem_ack,
    input  logic [DATA_W-1:0]  dmem_rdata,
    output logic [31:0]        pc,
    output logic               halted,
    output logic               err
);
    localparam int RI_W = $clog2(NREG);
    localparam logic [RI_W-1:0] RA = RI_W'(NREG - 1);

    state_e            state, nextState;
    logic [31:0]       ir, pcPlus4, target;
    flags_t            flags;
    logic [DATA_W-1:0] regs [NREG];
    logic [DATA_W-1:0] opA, opB, immx, immNext, res, mdr, aluB, aluRes;
    logic [RI_W-1:0]   rs1Idx, rs2Idx, rdIdx;
    logic [15:0]       imm16;
    logic              fill, aluE, aluGt, taken;
    opcode_e           op;

    assign op = opcode_e'(ir[OP_LO +: 5]);
    assign rs1Idx = op == OP_RET ? RA : ir[RS1_LO +: RI_W];
    assign rs2Idx = op == OP_ST ? ir[RD_LO +: RI_W] : ir[RS2_LO +: RI_W];
    assign rdIdx = op == OP_CALL ? RA : ir[RD_LO +: RI_W];

    // imm[17:16]: 00 sign-extend, 01 zero-extend, 10 ones-fill, 11 upper halfword
    assign imm16 = ir[15:0];
    assign fill = ir[17:16] == 2'b00 ? imm16[15] : ir[17:16] == 2'b10;
    assign immNext = ir[17:16] == 2'b11 ? DATA_W'({imm16, 16'h0000}) : {{(DATA_W-16){fill}}, imm16};

    assign aluB = ir[I_BIT] ? immx : opB;
    assign pcPlus4 = pc + 32'd4;
    assign target = op == OP_RET ? opA[31:0] : pc + {{3{ir[26]}}, ir[26:0], 2'b00};
    assign taken = op inside {OP_B, OP_CALL, OP_RET} || (op == OP_BEQ && flags.e) || (op == OP_BGT && flags.gt);

    dp_alu #(.DATA_W(DATA_W)) uAlu (
        .A      (opA),
        .B      (aluB),
        .op     (op),
        .result (aluRes),
        .E      (aluE),
        .GT     (aluGt)
    );

    assign imem_addr = pc[IADDR_W+1:2];
    assign dmem_addr = res[DADDR_W+1:2];
    assign dmem_wdata = opB;
    assign dmem_we = op == OP_ST;
    assign halted = state == S_HALT && !rst;
    assign err = state == S_HALT && !rst;

    always_ff @(posedge clk)
        state <= rst ? S_FETCH : nextState;

    always_comb begin
        nextState = state;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        case (state)
            S_FETCH: begin
                imem_req = 1'b1;
                nextState = imem_ack ? S_DECODE : S_FETCH;
            end
            S_DECODE: nextState = isLegal(ir[OP_LO +: 5]) ? S_EXEC : S_HALT;
            S_EXEC: nextState = op inside {OP_LD, OP_ST} ? S_MEM :
                                op inside {OP_CMP, OP_NOP, OP_B, OP_BEQ, OP_BGT, OP_RET} ? S_FETCH : S_WB;
            S_MEM: begin
                dmem_req = 1'b1;
                nextState = !dmem_ack ? S_MEM : op == OP_LD ? S_WB : S_FETCH;
            end
            S_WB: nextState = S_FETCH;
            default: nextState = S_HALT;
        endcase
        if (rst) begin
            imem_req = 1'b0;
            dmem_req = 1'b0;
        end
    end

    always_ff @(posedge clk)
        if (rst) begin
            pc <= '0;
            ir <= '0;
            flags <= '0;
            opA <= '0;
            opB <= '0;
            immx <= '0;
            res <= '0;
            mdr <= '0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else
            case (state)
                S_FETCH: if (imem_ack) ir <= imem_rdata;
                S_DECODE: begin
                    opA <= regs[rs1Idx];
                    opB <= regs[rs2Idx];
                    immx <= immNext;
                end
                S_EXEC: begin
                    res <= op == OP_CALL ? DATA_W'(pcPlus4) : aluRes;
                    if (op == OP_CMP) flags <= '{e: aluE, gt: aluGt};
                    pc <= taken ? target : pcPlus4;
                end
                S_MEM: if (dmem_ack && op == OP_LD) mdr <= dmem_rdata;
                S_WB: regs[rdIdx] <= op == OP_LD ? mdr : res;
                default: ;
            endcase
endmodule

// File: tb/tb_multicycle_datapath.sv
// tb_multicycle_datapath: directed programs with fetch/memory scoreboards checked by a decoupled monitor
module tb_multicycle_datapath;
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } memEv_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, halted, err;
    logic [9:0]  imem_addr, dmem_addr;
    logic [31:0] imem_rdata, dmem_wdata, dmem_rdata, pc;

    logic [31:0] imem [1024];
    logic [31:0] dmem [1024];
    logic [31:0] fetchQ [$];
    memEv_t      memQ [$];
    int          iDelay = 1, dDelay = 3;
    int          checks = 0, passes = 0;

    multicycle_datapath dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .pc         (pc),
        .halted     (halted),
        .err        (err)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] asmR(input int op, input int rd, input int rs1, input int rs2);
        return {5'(op), 1'b0, 4'(rd), 4'(rs1), 4'(rs2), 14'd0};
    endfunction

    function automatic logic [31:0] asmI(input int op, input int rd, input int rs1, input int mode, input int imm);
        return {5'(op), 1'b1, 4'(rd), 4'(rs1), 2'(mode), 16'(imm)};
    endfunction

    function automatic logic [31:0] asmB(input int op, input int off);
        return {5'(op), 27'(off)};
    endfunction

    task automatic put(input int addr, input logic [31:0] word);
        imem[addr >> 2] = word;
    endtask

    task automatic pushMem(input logic we, input logic [31:0] addr, input logic [31:0] data);
        memEv_t ev;
        ev.we = we;
        ev.addr = addr;
        ev.data = data;
        memQ.push_back(ev);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    // instruction memory: iDelay wait cycles before each ack
    initial begin
        int cnt = 0;
        imem_ack = 1'b0;
        imem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            imem_ack = 1'b0;
            if (rst || !imem_req) cnt = 0;
            else if (cnt >= iDelay) begin
                imem_ack = 1'b1;
                imem_rdata = imem[imem_addr];
                cnt = 0;
            end else cnt++;
        end
    end

    // data memory: dDelay wait cycles before each ack
    initial begin
        int cnt = 0;
        dmem_ack = 1'b0;
        dmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            dmem_ack = 1'b0;
            if (rst || !dmem_req) cnt = 0;
            else if (cnt >= dDelay) begin
                dmem_ack = 1'b1;
                cnt = 0;
                if (dmem_we) dmem[dmem_addr] = dmem_wdata;
                else dmem_rdata = dmem[dmem_addr];
            end else cnt++;
        end
    end

    initial forever begin
        @(negedge clk);
        if (imem_req) begin
            if (fetchQ.size() == 0) check("unexpected_fetch", imem_req, 0);
            else begin
                check("imem_addr", imem_addr, fetchQ[0][11:2]);
                if (imem_ack) begin
                    check("fetch_pc", pc, fetchQ[0]);
                    void'(fetchQ.pop_front());
                end
            end
        end
        if (dmem_req) begin
            if (memQ.size() == 0) check("unexpected_dmem", dmem_req, 0);
            else begin
                check("dmem_we", dmem_we, memQ[0].we);
                check("dmem_addr", dmem_addr, memQ[0].addr[11:2]);
                if (memQ[0].we) check("dmem_wdata", dmem_wdata, memQ[0].data);
                if (dmem_ack) void'(memQ.pop_front());
            end
        end
    end

    initial begin
        int n;
        int seq [] = '{'h00, 'h04, 'h08, 'h0C, 'h10, 'h14, 'h18, 'h1C, 'h20, 'h2C, 'h30, 'h34,
                      'h38, 'h40, 'h60, 'h44, 'h48, 'h4C, 'h50, 'h54, 'h58, 'h5C, 'h64, 'h68,
                      'h6C, 'h70, 'h74, 'h78, 'h7C, 'h80, 'h84, 'h8C, 'h90};
        for (int i = 0; i < 1024; i++) begin
            imem[i] = 32'h1000_0000;
            dmem[i] = '0;
        end
        put('h00, asmI(9, 1, 0, 0, 5));
        put('h04, asmI(9, 2, 0, 0, 'hFFFD));
        put('h08, asmR(0, 3, 1, 2));
        put('h0C, asmI(10, 4, 1, 1, 4));
        put('h10, asmI(9, 1, 0, 0, 7));
        put('h14, asmI(9, 2, 0, 0, 7));
        put('h18, asmR(5, 0, 1, 2));
        put('h1C, asmR(13, 0, 0, 0));
        put('h20, asmB(16, 3));
        put('h2C, asmB(17, 5));
        put('h30, asmI(15, 3, 0, 1, 'h100));
        put('h34, asmI(15, 4, 0, 1, 'h104));
        put('h38, asmB(18, 2));
        put('h40, asmB(19, 8));
        put('h44, asmI(15, 15, 0, 1, 'h108));
        put('h48, asmI(9, 1, 0, 3, 'hDEAD));
        put('h4C, asmI(7, 1, 1, 1, 'hBEEF));
        put('h50, asmI(15, 1, 0, 1, 8));
        put('h54, asmI(14, 5, 0, 1, 8));
        put('h58, asmI(15, 5, 0, 1, 'h10C));
        put('h5C, asmB(18, 2));
        put('h60, asmB(20, 0));
        put('h64, asmI(9, 6, 0, 0, 'h8000));
        put('h68, asmI(12, 7, 6, 1, 4));
        put('h6C, asmI(11, 8, 6, 1, 4));
        put('h70, asmI(15, 7, 0, 1, 'h110));
        put('h74, asmI(15, 8, 0, 1, 'h114));
        put('h78, asmI(9, 9, 0, 2, 'h1234));
        put('h7C, asmI(15, 9, 0, 1, 'h118));
        put('h80, asmR(5, 0, 8, 7));
        put('h84, asmB(17, 2));
        put('h8C, asmB(16, 2));
        cyc(3);
        check("rst_pc", pc, 0);
        check("rst_imem_req", imem_req, 0);
        check("rst_dmem_req", dmem_req, 0);
        check("rst_halted", halted, 0);
        check("rst_err", err, 0);
        foreach (seq[i]) fetchQ.push_back(32'(seq[i]));
        pushMem(1, 'h100, 2);
        pushMem(1, 'h104, 80);
        pushMem(1, 'h108, 'h44);
        pushMem(1, 'h8, 'hDEADBEEF);
        pushMem(0, 'h8, 0);
        pushMem(1, 'h10C, 'hDEADBEEF);
        pushMem(1, 'h110, 'hFFFFF800);
        pushMem(1, 'h114, 'h0FFFF800);
        pushMem(1, 'h118, 'hFFFF1234);
        rst = 1'b0;
        #1;
        check("first_imem_req", imem_req, 1);
        check("first_imem_addr", imem_addr, 0);
        n = 0;
        while (!halted && n < 3000) begin
            cyc(1);
            n++;
        end
        check("prog1_halted", halted, 1);
        check("prog1_err", err, 1);
        cyc(5);
        check("halt_no_fetch", imem_req, 0);
        check("halt_pc_frozen", pc, 'h90);
        check("prog1_fetches_left", fetchQ.size(), 0);
        check("prog1_mem_left", memQ.size(), 0);

        rst = 1'b1;
        cyc(1);
        check("rst_clears_halt", halted, 0);
        put('h00, asmI(15, 0, 0, 1, 'h20));
        put('h04, 32'hA800_0000);
        iDelay = 0;
        dDelay = 50;
        fetchQ.push_back(0);
        pushMem(1, 'h20, 0);
        rst = 1'b0;
        n = 0;
        while (!dmem_req && n < 50) begin
            cyc(1);
            n++;
        end
        check("mem_wait_reached", dmem_req, 1);
        cyc(2);
        rst = 1'b1;
        cyc(1);
        check("midrst_dmem_req", dmem_req, 0);
        check("midrst_pc", pc, 0);
        check("midrst_imem_req", imem_req, 0);
        check("midrst_fetches_left", fetchQ.size(), 0);
        memQ.delete();
        dDelay = 0;
        fetchQ.push_back(0);
        fetchQ.push_back(4);
        pushMem(1, 'h20, 0);
        rst = 1'b0;
        #1;
        check("refetch_imem_req", imem_req, 1);
        check("refetch_imem_addr", imem_addr, 0);
        n = 0;
        while (!halted && n < 200) begin
            cyc(1);
            n++;
        end
        check("illegal21_err", err, 1);
        cyc(3);
        check("illegal21_pc", pc, 4);
        check("prog2_fetches_left", fetchQ.size(), 0);
        check("prog2_mem_left", memQ.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/multicycle_datapath.md
MULTICYCLE_DATAPATH -- requirements
Module: multicycle_datapath

Interface
REQ-001 Parameters (name, default, meaning):
- DATA_W, 32, register/ALU width; legal values 32 or 64.
- NREG, 16, register count; power of 2, 4..16.
- IADDR_W, 10, instruction word-address width.
- DADDR_W, 10, data word-address width.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, sole clock; all state changes on rising edge.
- rst, in, 1, synchronous, active-high reset.
- imem_req, out, 1, fetch request.
- imem_addr, out, IADDR_W, word address = pc[IADDR_W+1:2].
- imem_ack, in, 1, instruction valid this cycle.
- imem_rdata, in, 32, instruction.
- dmem_req, out, 1, data access request.
- dmem_we, out, 1, 1 = store, 0 = load.
- dmem_addr, out, DADDR_W, alu_result[DADDR_W+1:2].
- dmem_wdata, out, DATA_W, store data.
- dmem_ack, in, 1, access complete; rdata valid on loads.
- dmem_rdata, in, DATA_W, load data.
- pc, out, 32, current byte PC.
- halted, out, 1, core stopped.
- err, out, 1, illegal opcode seen.

Function
REQ-003 Fields: op[31:27], I[26], rd[25:22], rs1[21:18], rs2[17:14], imm[17:0], branch offset[26:0]; register indices use low log2(NREG) bits; ra = register NREG-1.
REQ-004 Opcodes: add 0, sub 1, cmp 5, and 6, or 7, not 8, mov 9, lsl 10, lsr 11, asr 12, nop 13, ld 14, st 15, beq 16, bgt 17, b 18, call 19, ret 20; all others (incl. 2-4, 21-31) illegal.
REQ-005 States: FETCH, DECODE, EXEC, MEM, WB, HALT; one state per cycle except FETCH/MEM, which hold until ack.
REQ-006 FETCH: imem_req=1 and imem_addr stable until imem_ack; on ack, capture IR, go DECODE; req drops the cycle after ack.
REQ-007 DECODE: read rs1 (ra for ret) and rs2 (rd for st); form immx:
- imm[17:16]=00: sign-extend imm[15:0].
- 01: zero-extend.
- 10: ones-fill.
- 11: imm[15:0]<<16, zero-extend.
REQ-008 EXEC: B = I ? immx : rs2 value; result is DATA_W-bit with wrap-around; shift amount = B[log2(DATA_W)-1:0]; asr sign-fills; not/mov use B only.
REQ-009 cmp sets flags E=(A==B), GT=(signed A > signed B); flags hold until the next cmp; no other op changes flags.
REQ-010 Branch taken if b, call, ret, beq&E, or bgt&GT.
- Target = pc + (sign-extended offset << 2); ret target = ra value truncated/zero-extended to 32 bits.
- call writes pc+4 into ra.
REQ-011 PC updates on EXEC exit: taken-branch target, else pc+4.
REQ-012 EXEC next state:
- ld/st -> MEM.
- cmp, nop, b, beq, bgt, ret -> FETCH.
- all others -> WB.
REQ-013 MEM: dmem_req=1 with addr, we and wdata stable until dmem_ack.
- Load: capture rdata on ack, go WB.
- Store: go FETCH on ack.
REQ-014 WB: write rd (ra for call) with ALU result, load data or pc_old+4, go FETCH.
REQ-015 ALU-type instruction with same-cycle acks takes 4 cycles; load 5; store 4; taken branch 3.
REQ-016 Illegal opcode detected in DECODE -> HALT: err=1, halted=1, no requests, no register/PC change, until rst.
REQ-017 Fetch wrap-around: pc overflow beyond IADDR_W wraps naturally through truncated imem_addr; no error.

Reset
REQ-018 While rst=1: state=FETCH-pending, pc=0, flags=0, all registers=0, IR=0, imem_req=0, dmem_req=0, halted=0, err=0.
REQ-019 First cycle after rst falls: imem_req=1, imem_addr=0.
REQ-020 rst mid-request abandons the access; memories share rst, so no stale ack is accepted.

Structure
REQ-021 cpu_pkg holds the opcode enum, state enum, flags struct, and instruction field-position constants.
REQ-022 A single sub-module dp_alu (parametrised DATA_W; inputs A, B, op; outputs result, E, GT) is instantiated; the register file is internal.

Verification
REQ-023 Load immediates and add: mov r1,#5; mov r2,#-3 (mode 00) -> add r3,r1,r2 gives r3=2; lsl r4,r1,#4 gives r4=80.
REQ-024 Compare and branch: cmp r1=7, r2=7; beq +3 at pc=0x20 -> pc=0x2C; bgt not taken -> pc+4.
REQ-025 Call/return: call at 0x40 -> ra=0x44, pc=target; ret -> pc=0x44.
REQ-026 Memory wait states: st r1=0xDEADBEEF to addr 8 with dmem_ack delayed 3 cycles -> req and inputs held stable; ld r5 from 8 -> r5=0xDEADBEEF; imem_ack delays honoured.
REQ-027 Illegal opcode 2 -> err=1, halted=1 after DECODE; no further imem_req until rst.
REQ-028 rst asserted during MEM wait -> next cycle dmem_req=0, pc=0; after release, fetch begins at address 0.
